// File: rtl/stim_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stim_player_pkg
//  Description : Shared definitions for the stimulus player: playback state
//                encoding, response-signature MISR constants and the MISR
//                single-step update function.
//  Revision    : 1.0 - initial release
// ============================================================================
package stim_player_pkg;

  // Playback sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Galois-form feedback taps for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] C_MISR_POLY = 16'hB400;
  localparam logic [15:0] C_MISR_SEED = 16'hFFFF;

  // One MISR step: shift right, apply feedback taps when the bit shifted out
  // is set, then fold in the 16-bit response word.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] data);
    logic [15:0] shifted;
    shifted = {1'b0, sig[15:1]};
    if (sig[0]) begin
      shifted = shifted ^ C_MISR_POLY;
    end
    return shifted ^ data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_misr.sv
`default_nettype none
// ============================================================================
//  Module      : stim_misr
//  Description : 16-bit multiple-input signature register compacting the
//                device response. Reseeded when playback is accepted, folds
//                one response word per cycle while fold is high, otherwise
//                holds.
//  Ports       : clock   in  1      rising-edge clock
//                reset   in  1      synchronous, active-low
//                seed    in  1      reload the seed value
//                fold    in  1      compact resp_in this cycle
//                resp_in in  VEC_W  response word (resized to 16 bits)
//                sig_out out 16     current signature
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_misr
  import stim_player_pkg::*;
#(
  parameter int VEC_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed,
  input  logic             fold,
  input  logic [VEC_W-1:0] resp_in,
  output logic [15:0]      sig_out
);

  logic [15:0] w_resp16;
  logic [15:0] r_sig;

  // Response is zero-extended when narrower than 16 bits, truncated when wider.
  generate
    if (VEC_W >= 16) begin : g_trunc
      logic unused_resp_hi;
      assign w_resp16       = resp_in[15:0];
      assign unused_resp_hi = ^resp_in;
    end else begin : g_ext
      assign w_resp16 = {{(16-VEC_W){1'b0}}, resp_in};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sig <= C_MISR_SEED;
    end else if (seed) begin
      r_sig <= C_MISR_SEED;
    end else if (fold) begin
      r_sig <= misr_next(r_sig, w_resp16);
    end
  end

  assign sig_out = r_sig;

endmodule
`default_nettype wire

// File: rtl/stim_player.sv
`default_nettype none
// ============================================================================
//  Module      : stim_player
//  Description : Programmable stimulus sequencer. A program of DEPTH entries
//                {hold, vec} is written while idle; on start the first len
//                entries are played back, each held on vec_out for hold+1
//                cycles, optionally looping. Program memory is a synchronous
//                read RAM that is prefetched one entry ahead so consecutive
//                entries follow each other without a gap cycle.
//                Optional feature macro: STIM_PLAYER_SIG_EN adds a 16-bit
//                MISR signature of resp_in on sig_out (tied to 0 otherwise).
//  Ports       : clock     in  1             rising-edge clock
//                reset     in  1             synchronous, active-low
//                ld_en     in  1             program write strobe (idle only)
//                ld_addr   in  ADDR_W        program write address
//                ld_data   in  HOLD_W+VEC_W  entry {hold, vec}
//                start     in  1             begin playback
//                stop      in  1             abort playback
//                loop_en   in  1             wrap to entry 0 after last entry
//                len       in  ADDR_W+1      entries to play (clamped to DEPTH)
//                resp_in   in  VEC_W         device response for the signature
//                vec_out   out VEC_W         current stimulus vector
//                vec_valid out 1             vec_out carries a program vector
//                pc        out ADDR_W        index of the entry on vec_out
//                busy      out 1             sequencer not idle
//                done      out 1             one-cycle end-of-program pulse
//                sig_out   out 16            response signature
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_player
  import stim_player_pkg::*;
#(
  parameter  int VEC_W  = 12,
  parameter  int DEPTH  = 1024,
  parameter  int HOLD_W = 4,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [HOLD_W+VEC_W-1:0] ld_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDR_W:0]         len,
  input  logic [VEC_W-1:0]        resp_in,
  output logic [VEC_W-1:0]        vec_out,
  output logic                    vec_valid,
  output logic [ADDR_W-1:0]       pc,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             sig_out
);

  localparam int              ENT_W   = HOLD_W + VEC_W;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  // Sequencer state
  state_t r_state;
  state_t w_state_nxt;

  // Program memory and its registered read port
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ENT_W-1:0]  r_rdata;
  logic [ADDR_W-1:0] w_rd_addr;

  // Playback datapath
  logic [VEC_W-1:0]  r_vec;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [HOLD_W-1:0] r_hold;     // remaining extra cycles for the shown entry
  logic [ADDR_W-1:0] r_nxt_idx;  // index of the entry sitting in r_rdata
  logic [ADDR_W:0]   r_last;     // index of the final entry of the program

  logic [ADDR_W:0]   w_len_eff;
  logic [ADDR_W-1:0] w_after_nxt;
  logic              w_pc_is_last;
  logic              w_nxt_is_last;

  // Control strobes from the state machine
  logic w_accept;
  logic w_load;
  logic w_finish;
  logic w_abort;

  assign w_len_eff     = (len > C_DEPTH) ? C_DEPTH : len;
  assign w_pc_is_last  = ({1'b0, r_pc} == r_last);
  assign w_nxt_is_last = ({1'b0, r_nxt_idx} == r_last);
  // Prefetch always wraps to entry 0 after the last entry; whether that entry
  // is actually used is decided by loop_en at the end of the last entry.
  assign w_after_nxt   = w_nxt_is_last ? '0 : r_nxt_idx + ADDR_W'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    w_rd_addr   = r_nxt_idx;

    case (r_state)
      ST_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop && (len != '0)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PLAY;
          w_rd_addr   = '0;
        end
      end

      ST_PLAY: begin
        if (stop) begin
          // Abort takes priority over an entry finishing in the same cycle.
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!r_valid || (r_hold == '0)) begin
          // Either the first entry is waiting in r_rdata, or the entry on
          // vec_out has used up its hold time.
          if (r_valid && w_pc_is_last && !loop_en) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_load    = 1'b1;
            w_rd_addr = w_after_nxt;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Program memory: writes only while idle, synchronous read every cycle.
  // Not reset so contents survive a reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if ((r_state == ST_IDLE) && ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
    r_rdata <= r_mem[w_rd_addr];
  end

  // --------------------------------------------------------------------------
  // Playback datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vec     <= '0;
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_hold    <= '0;
      r_nxt_idx <= '0;
      r_last    <= '0;
    end else begin
      if (w_accept) begin
        r_nxt_idx <= '0;
        r_last    <= w_len_eff - (ADDR_W+1)'(1);
      end

      if (w_abort || w_finish) begin
        r_vec   <= '0;
        r_valid <= 1'b0;
        r_pc    <= '0;
        r_hold  <= '0;
      end else if (w_load) begin
        r_vec     <= r_rdata[VEC_W-1:0];
        r_hold    <= r_rdata[ENT_W-1:VEC_W];
        r_pc      <= r_nxt_idx;
        r_valid   <= 1'b1;
        r_nxt_idx <= w_rd_addr;
      end else if (r_valid && (r_hold != '0)) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
    end
  end

  assign vec_out   = r_vec;
  assign vec_valid = r_valid;
  assign pc        = r_pc;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

  // --------------------------------------------------------------------------
  // Optional response signature
  // --------------------------------------------------------------------------
`ifdef STIM_PLAYER_SIG_EN
  stim_misr #(
    .VEC_W (VEC_W)
  ) u_misr (
    .clock   (clock),
    .reset   (reset),
    .seed    (w_accept),
    .fold    (r_valid),
    .resp_in (resp_in),
    .sig_out (sig_out)
  );
`else
  logic unused_resp;
  assign unused_resp = ^resp_in;
  assign sig_out     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stim_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stim_player
//  Description : Self-checking bench for stim_player. A vector table covers
//                the basic three-entry program, hand sequences cover loop,
//                stop, reset and ignored-command cases, and randomized
//                programs are compared against a trace model built from the
//                program contents. Honors STIM_PLAYER_SIG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_player;

  localparam int VEC_W  = 12;
  localparam int DEPTH  = 16;
  localparam int HOLD_W = 4;
  localparam int ADDR_W = 4;
  localparam int ENT_W  = HOLD_W + VEC_W;

`ifdef STIM_PLAYER_SIG_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  logic              clock    = 1'b0;
  logic              reset    = 1'b0;
  logic              ld_en    = 1'b0;
  logic [ADDR_W-1:0] ld_addr  = '0;
  logic [ENT_W-1:0]  ld_data  = '0;
  logic              start    = 1'b0;
  logic              stop     = 1'b0;
  logic              loop_en  = 1'b0;
  logic [ADDR_W:0]   len      = '0;
  logic [VEC_W-1:0]  resp_drv = '0;
  logic              loopback = 1'b0;
  logic [VEC_W-1:0]  resp_in;
  logic [VEC_W-1:0]  vec_out;
  logic              vec_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [15:0]       sig_out;

  assign resp_in = loopback ? vec_out : resp_drv;

  always #5 clock = ~clock;

  stim_player #(
    .VEC_W  (VEC_W),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .len       (len),
    .resp_in   (resp_in),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .sig_out   (sig_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Table record: inputs for one cycle, outputs expected in the next cycle.
  typedef struct {
    logic             start;
    logic             stop;
    logic             loop_en;
    logic             e_valid;
    logic [VEC_W-1:0] e_vec;
    logic [ADDR_W-1:0] e_pc;
    logic             e_busy;
    logic             e_done;
  } vec_rec_t;
  vec_rec_t tbl [7];

  // Expected per-cycle output trace of one randomized playback.
  typedef struct {
    logic              v;
    logic [VEC_W-1:0]  vec;
    logic [ADDR_W-1:0] p;
    logic              busy;
    logic              done;
    logic              bnd;   // last cycle of the last entry
  } tr_t;
  tr_t q [$];

  logic [ENT_W-1:0] shadow [DEPTH];
  logic [VEC_W-1:0] lp_seq [8] = '{12'd1, 12'd2, 12'd2, 12'd3, 12'd1, 12'd2, 12'd2, 12'd3};
  logic [15:0]      m_sig;
  logic [15:0]      ref_sig;
  logic [VEC_W-1:0] resp_now;
  int               lenv, leff, s_idx, passes;
  bit               lp, has_stop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [HOLD_W-1:0] h, input logic [VEC_W-1:0] v);
    ld_en   = 1'b1;
    ld_addr = a[ADDR_W-1:0];
    ld_data = {h, v};
    tick();
    ld_en     = 1'b0;
    shadow[a] = {h, v};
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_vec"},   vec_out,   0);
    chk({tag, "_valid"}, vec_valid, 0);
    chk({tag, "_pc"},    pc,        0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_done"},  done,      0);
    chk({tag, "_sig"},   sig_out,   SIG_ON ? 32'hFFFF : 32'h0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 7; i++) begin
      start   = tbl[i].start;
      stop    = tbl[i].stop;
      loop_en = tbl[i].loop_en;
      tick();
      chk({tag, "_valid"}, vec_valid, tbl[i].e_valid);
      chk({tag, "_vec"},   vec_out,   tbl[i].e_vec);
      chk({tag, "_busy"},  busy,      tbl[i].e_busy);
      chk({tag, "_done"},  done,      tbl[i].e_done);
      if (tbl[i].e_valid) chk({tag, "_pc"}, pc, tbl[i].e_pc);
    end
    start = 1'b0;
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [VEC_W-1:0] d);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n ^ 16'(d);
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // start, stop, loop | valid, vec, pc, busy, done
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd1, 4'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd2, 4'd1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd2, 4'd1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd3, 4'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 4'd0, 1'b0, 1'b0};

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();

    // Basic three-entry program
    load(0, 4'd0, 12'd1);
    load(1, 4'd1, 12'd2);
    load(2, 4'd0, 12'd3);
    len = 5'd3;
    run_table("basic");

`ifdef STIM_PLAYER_SIG_EN
    // Loopback signature, two identical runs
    ref_sig = 16'hFFFF;
    ref_sig = misr_ref(ref_sig, 12'd1);
    ref_sig = misr_ref(ref_sig, 12'd2);
    ref_sig = misr_ref(ref_sig, 12'd2);
    ref_sig = misr_ref(ref_sig, 12'd3);
    loopback = 1'b1;
    run_table("sig_run1");
    chk("sig_run1_value", sig_out, ref_sig);
    run_table("sig_run2");
    chk("sig_run2_value", sig_out, ref_sig);
    loopback = 1'b0;
`endif

    // Looping playback, then stop
    loop_en = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("loop_wait_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("loop_valid", vec_valid, 1);
      chk("loop_vec",   vec_out,   lp_seq[k]);
      chk("loop_pc",    pc,        lp_seq[k] - 12'd1);
      chk("loop_done",  done,      0);
    end
    stop = 1'b1;
    tick();
    stop    = 1'b0;
    loop_en = 1'b0;
    chk("loop_stop_valid", vec_valid, 0);
    chk("loop_stop_busy",  busy,      0);
    chk("loop_stop_done",  done,      0);

    // Stop during the second entry
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("stop_pre_vec", vec_out, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", vec_valid, 0);
    chk("stop_vec",   vec_out,   0);
    chk("stop_busy",  busy,      0);
    chk("stop_done",  done,      0);
    tick();
    chk("stop_after_done", done, 0);
    chk("stop_after_busy", busy, 0);

    // stop beats start in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", busy, 0);

    // Reset in the middle of playback, program must survive
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_vals("midreset");
    reset = 1'b1;
    run_table("after_reset");

    // len = 0 is ignored
    len   = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_busy",  busy,      0);
    chk("len0_valid", vec_valid, 0);
    tick();
    chk("len0_busy2", busy, 0);

    // Writes during playback are ignored
    len   = 5'd3;
    start = 1'b1;
    tick();
    start   = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 4'd0;
    ld_data = {4'd5, 12'hABC};
    repeat (5) tick();
    ld_en = 1'b0;
    tick();
    run_table("after_ld");

    // Randomized programs against the trace model
    for (int it = 0; it < 14; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (it == 0 || $urandom_range(0, 1) == 1)
          load(a, ($urandom_range(0, 3) == 0) ? 4'hF : HOLD_W'($urandom_range(0, 2)),
               VEC_W'($urandom));
      end
      lenv = (it == 0) ? DEPTH : (it == 1) ? 31 : (it == 2) ? 1 : int'($urandom_range(1, 31));
      leff = (lenv > DEPTH) ? DEPTH : lenv;
      lp   = (it >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      passes = lp ? 3 : 1;

      q.delete();
      q.push_back('{1'b0, '0, '0, 1'b1, 1'b0, 1'b0});
      for (int p = 0; p < passes; p++) begin
        for (int e = 0; e < leff; e++) begin
          int h;
          h = int'(shadow[e][ENT_W-1:VEC_W]);
          for (int r = 0; r <= h; r++)
            q.push_back('{1'b1, shadow[e][VEC_W-1:0], e[ADDR_W-1:0], 1'b1, 1'b0,
                          (e == leff - 1) && (r == h)});
        end
      end
      if (!lp) begin
        q.push_back('{1'b0, '0, '0, 1'b1, 1'b1, 1'b0});
        q.push_back('{1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      end
      has_stop = lp || ($urandom_range(0, 2) == 0);
      if (has_stop) begin
        s_idx = lp ? int'($urandom_range(0, q.size() - 1)) : int'($urandom_range(0, q.size() - 3));
        while (q.size() > s_idx + 1) void'(q.pop_back());
        q.push_back('{1'b0, '0, '0, 1'b0, 1'b0, 1'b0});
      end else begin
        s_idx = -1;
      end

      len     = (ADDR_W+1)'(lenv);
      stop    = 1'b0;
      start   = 1'b1;
      loop_en = 1'($urandom);
      tick();
      start = 1'b0;
      m_sig = 16'hFFFF;
      for (int j = 0; j < q.size(); j++) begin
        chk("rnd_valid", vec_valid, q[j].v);
        chk("rnd_vec",   vec_out,   q[j].vec);
        chk("rnd_busy",  busy,      q[j].busy);
        chk("rnd_done",  done,      q[j].done);
        if (q[j].v) chk("rnd_pc", pc, q[j].p);
        chk("rnd_sig", sig_out, SIG_ON ? m_sig : 16'h0);
        if (j == q.size() - 1) break;
        stop     = has_stop && (j == s_idx);
        start    = ($urandom_range(0, 3) == 0);
        loop_en  = q[j].bnd ? lp : 1'($urandom);
        ld_en    = 1'($urandom);
        ld_addr  = ADDR_W'($urandom);
        ld_data  = ENT_W'($urandom);
        resp_now = VEC_W'($urandom);
        resp_drv = resp_now;
        tick();
        if (q[j].v) m_sig = misr_ref(m_sig, resp_now);
      end
      start   = 1'b0;
      stop    = 1'b0;
      ld_en   = 1'b0;
      loop_en = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
